// File: rtl/uart_echo_buffer.sv
// Buffered UART echo core: rx characters go through a FIFO to a busy-aware transmit handshake FSM.
// Build macro UART_ECHO_UPPER_EN folds 'a'..'z' to upper case at launch; undefined by default.
module uart_echo_buffer #(
    parameter int DATABITS = 8,
    parameter int DEPTH    = 16,
    parameter int CNTW     = 8
) (
    input  logic                    I_clk,
    input  logic                    I_rstn,
    input  logic [DATABITS-1:0]     I_rx_data,
    input  logic                    I_rx_valid,
    input  logic                    I_rx_error,
    input  logic                    I_tx_busy,
    output logic [DATABITS-1:0]     O_tx_data,
    output logic                    O_tx_en,
    input  logic                    I_flush,
    input  logic                    I_clr_status,
    output logic [$clog2(DEPTH):0]  O_level,
    output logic                    O_empty,
    output logic                    O_full,
    output logic                    O_overflow,
    output logic [CNTW-1:0]         O_err_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    logic [DATABITS-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    state_t              state;
    state_t              state_nxt;
    logic [1:0]          timer;
    logic [1:0]          timer_nxt;
    logic                launch;
    logic                push_req;
    logic                push_ok;
    logic                drop;
    logic [DATABITS-1:0] head;
    logic [DATABITS-1:0] head_out;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign O_empty = (wr_ptr == rd_ptr);
    assign O_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign O_level = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Flush wins over both a launch (pop) and a push in the same cycle.
    assign launch   = (state == S_IDLE) && !O_empty && !I_tx_busy && !I_flush;
    assign push_req = I_rx_valid && !I_rx_error && !I_flush;
    assign push_ok  = push_req && (!O_full || launch);
    assign drop     = push_req && O_full && !launch;

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid,
    // which keeps the array mappable onto RAM.
    always_ff @(posedge I_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= I_rx_data;
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so all registers update from
    // pre-edge values, independent of process order.
    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (I_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (launch)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

`ifdef UART_ECHO_UPPER_EN
    logic [7:0] head_low;

    // Subtracting 8'h20 from 8'h61..8'h7A never borrows past bit 7, so upper bits pass through.
    always_comb begin
        head_low = 8'(head);
        head_out = head;
        if (head_low >= 8'h61 && head_low <= 8'h7A) begin
            head_out = head - DATABITS'(8'h20);
        end
    end
`else
    assign head_out = head;
`endif

    // NOTE: next-state values get defaults before the case so no path leaves them unassigned,
    // which would infer latches.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                if (launch) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT_BUSY;
                timer_nxt = '0;
            end
            S_WAIT_BUSY: begin
                if (I_tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (timer == 2'd3) begin
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer + 2'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!I_tx_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state     <= S_IDLE;
            timer     <= '0;
            O_tx_en   <= 1'b0;
            O_tx_data <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            O_tx_en <= launch;
            if (launch) O_tx_data <= head_out;
        end
    end

    // A set event in the same cycle as a clear leaves the flag set and the counter at one.
    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            O_overflow <= 1'b0;
            O_err_cnt  <= '0;
        end else begin
            if (drop) begin
                O_overflow <= 1'b1;
            end else if (I_clr_status) begin
                O_overflow <= 1'b0;
            end

            if (I_rx_error) begin
                if (I_clr_status) begin
                    O_err_cnt <= CNTW'(1);
                end else if (O_err_cnt != '1) begin
                    O_err_cnt <= O_err_cnt + CNTW'(1);
                end
            end else if (I_clr_status) begin
                O_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed self-checking bench for uart_echo_buffer with a simple transmitter busy model.
module tb_uart_echo_buffer;
    localparam int DATABITS = 8;
    localparam int DEPTH    = 16;
    localparam int CNTW     = 8;

    logic                clk = 1'b0;
    logic                rstn;
    logic [DATABITS-1:0] rx_data;
    logic                rx_valid;
    logic                rx_error;
    logic                tx_busy;
    logic [DATABITS-1:0] tx_data;
    logic                tx_en;
    logic                flush;
    logic                clr_status;
    logic [4:0]          level;
    logic                empty;
    logic                full;
    logic                overflow;
    logic [CNTW-1:0]     err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_tx     = 0;
    int n_before;
    logic [DATABITS-1:0] tx_log[$];
    int                  tx_cyc[$];

    logic auto_busy = 1'b0;
    logic busy_pend = 1'b0;
    int   busy_cnt  = 0;
    int   busy_hold = 12;

    logic [7:0] fold_in  [5];
    logic [7:0] fold_exp [5];

    always #5 clk = ~clk;

    uart_echo_buffer #(.DATABITS(DATABITS), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .I_clk(clk), .I_rstn(rstn), .I_rx_data(rx_data), .I_rx_valid(rx_valid),
        .I_rx_error(rx_error), .I_tx_busy(tx_busy), .O_tx_data(tx_data), .O_tx_en(tx_en),
        .I_flush(flush), .I_clr_status(clr_status), .O_level(level), .O_empty(empty),
        .O_full(full), .O_overflow(overflow), .O_err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample #1 after the edge, log strobes, and run the busy model
    // (busy rises the cycle after a strobe and holds for busy_hold cycles).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_busy) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end else if (busy_pend) begin
                tx_busy   = 1'b1;
                busy_cnt  = busy_hold;
                busy_pend = 1'b0;
            end
        end
        if (tx_en) begin
            tx_log.push_back(tx_data);
            tx_cyc.push_back(cyc);
            n_tx++;
            if (auto_busy) busy_pend = 1'b1;
        end
    endtask

    task automatic push(input logic [DATABITS-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
`ifdef UART_ECHO_UPPER_EN
        fold_exp = '{8'h41, 8'h5A, 8'h5B, 8'h60, 8'h7B};
`else
        fold_exp = '{8'h61, 8'h7A, 8'h5B, 8'h60, 8'h7B};
`endif
        fold_in = '{8'h61, 8'h7A, 8'h5B, 8'h60, 8'h7B};
        rstn = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_error = 1'b0;
        tx_busy = 1'b0; flush = 1'b0; clr_status = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_cnt", err_cnt, 0);
        rstn = 1'b1;
        tick(); tick();

        // Single char, long busy: strobe two cycles after the push
        auto_busy = 1'b1;
        busy_hold = 5208 * 10;
        push(8'h41);
        check("single_level_after_push", level, 1);
        check("single_no_early_en", tx_en, 0);
        tick();
        check("single_tx_en", tx_en, 1);
        check("single_tx_data", tx_data, 8'h41);
        check("single_level_after_pop", level, 0);
        for (int i = 0; i < busy_hold + 20; i++) tick();
        check("single_one_strobe", n_tx, 1);
        busy_hold = 12;

        // Burst of 20 with tx held busy: 16 stored, 4 dropped
        auto_busy = 1'b0;
        tx_busy   = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("burst_level16", level, 16);
        check("burst_full", full, 1);
        check("burst_no_overflow_yet", overflow, 0);
        clr_status = 1'b1;
        push(8'h10);
        clr_status = 1'b0;
        check("overflow_set_beats_clear", overflow, 1);
        for (int i = 17; i < 20; i++) push(8'(i));
        check("burst_level_still16", level, 16);
        check("burst_no_strobe_while_busy", n_tx, 1);
        tx_busy   = 1'b0;
        auto_busy = 1'b1;
        for (int i = 0; i < 2000 && n_tx < 17; i++) tick();
        check("burst_echo_count", n_tx, 17);
        for (int i = 0; i < 16; i++) check($sformatf("burst_order_%0d", i), tx_log[1+i], i);
        for (int i = 0; i < 40; i++) tick();
        check("burst_no_extra", n_tx, 17);
        check("burst_drained", empty, 1);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("overflow_cleared", overflow, 0);

        // Full FIFO with push coincident with a launch pop
        auto_busy = 1'b0;
        tx_busy   = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        check("fullpop_pre_full", full, 1);
        rx_data = 8'h30; rx_valid = 1'b1; tx_busy = 1'b0;
        tick();
        rx_valid = 1'b0; tx_busy = 1'b1;
        check("fullpop_level16", level, 16);
        check("fullpop_no_overflow", overflow, 0);
        check("fullpop_tx_en", tx_en, 1);
        check("fullpop_tx_data", tx_data, 8'h20);
        tick(); tick();
        flush = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        tick();
        flush = 1'b0; rx_valid = 1'b0;
        check("flush_push_level0", level, 0);
        check("flush_push_no_overflow", overflow, 0);
        tx_busy = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("flush_push_no_strobe", n_tx, 18);
        check("flush_keeps_tx_data", tx_data, 8'h20);

        // Flush at level 5 while in WAIT_DONE
        auto_busy = 1'b1;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        check("wd_level5", level, 5);
        check("wd_busy_active", tx_busy, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("wd_flush_level0", level, 0);
        check("wd_flush_empty", empty, 1);
        for (int i = 0; i < 40; i++) tick();
        check("wd_one_strobe", n_tx, 19);
        check("wd_char", tx_log[18], 8'h30);

        // Busy never asserted: WAIT_BUSY times out after 4 cycles
        auto_busy = 1'b0;
        tx_busy   = 1'b0;
        push(8'h41);
        push(8'h42);
        for (int i = 0; i < 30; i++) tick();
        check("nobusy_count", n_tx, 21);
        check("nobusy_gap", tx_cyc[20] - tx_cyc[19], 6);
        check("nobusy_char2", tx_log[20], 8'h42);

        // Error counter saturation, clear, and valid+error discard
        rx_error = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        check("err_255", err_cnt, 255);
        for (int i = 0; i < 45; i++) tick();
        rx_error = 1'b0;
        check("err_saturated", err_cnt, 255);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("err_cleared", err_cnt, 0);
        clr_status = 1'b1; rx_error = 1'b1; tick(); clr_status = 1'b0; rx_error = 1'b0;
        check("err_set_beats_clear", err_cnt, 1);
        rx_data = 8'h77; rx_valid = 1'b1; rx_error = 1'b1;
        tick();
        rx_valid = 1'b0; rx_error = 1'b0;
        check("valid_err_no_write", level, 0);
        check("valid_err_counted", err_cnt, 2);
        for (int i = 0; i < 10; i++) tick();
        check("valid_err_no_strobe", n_tx, 21);

        // Case folding (build-dependent expectation)
        auto_busy = 1'b1;
        n_before  = n_tx;
        for (int i = 0; i < 5; i++) push(fold_in[i]);
        for (int i = 0; i < 1000 && n_tx < n_before + 5; i++) tick();
        check("fold_count", n_tx, n_before + 5);
        for (int i = 0; i < 5; i++) check($sformatf("fold_%0d", i), tx_log[n_before+i], fold_exp[i]);
        for (int i = 0; i < 40; i++) tick();

        // Reset asserted mid-burst
        push(8'h01); push(8'h02); push(8'h03);
        check("midrst_pre_level", level, 2);
        check("midrst_pre_tx_data", tx_data, 8'h01);
        n_before = n_tx;
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        check("midrst_tx_en", tx_en, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_err_cnt", err_cnt, 0);
        auto_busy = 1'b0; busy_pend = 1'b0; busy_cnt = 0; tx_busy = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("postrst_no_strobe", n_tx, n_before);
        check("postrst_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
Buffered echo core placed between a uart_rx and a uart_tx instance. It replaces the direct rx-valid-to-tx-enable loopback with the following:
- a parametrised FIFO that absorbs bursts;
- a transmit handshake FSM that respects the transmitter's busy flag;
- receive-error accounting and overflow status.

The block is pure fabric logic on the UART clock domain and contains no baud logic.

Parameters:
DATABITS, 8, character width; must match uart_rx/uart_tx; 5..9.
DEPTH, 16, FIFO entries; power of two, >= 2.
CNTW, 8, width of the saturating receive-error counter.

Ports:
I_clk  in  1  system clock (UART mclk)
I_rstn  in  1  asynchronous active-low reset
I_rx_data  in  DATABITS  received character
I_rx_valid  in  1  one-cycle pulse; I_rx_data is valid
I_rx_error  in  1  one-cycle pulse; frame/parity error
I_tx_busy  in  1  transmitter busy
O_tx_data  out  DATABITS  character to transmit, held stable until the next launch
O_tx_en  out  1  one-cycle transmit strobe
I_flush  in  1  synchronous FIFO clear
I_clr_status  in  1  synchronous clear of O_overflow and O_err_cnt
O_level  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH
O_empty  out  1  level == 0
O_full  out  1  level == DEPTH
O_overflow  out  1  sticky; a character was dropped because the FIFO was full
O_err_cnt  out  CNTW  saturating count of I_rx_error pulses

Behaviour:
- Reset (I_rstn low, asynchronous):
  - pointers = 0, O_level = 0, O_empty = 1, O_full = 0;
  - O_tx_en = 0, O_tx_data = 0, O_overflow = 0, O_err_cnt = 0;
  - FSM = IDLE.
  - Reset mid-character drops the FIFO contents and any in-flight handshake; no O_tx_en is issued during or after release until new data arrives.
- Push, on a rising edge:
  - I_rx_valid=1, I_rx_error=0, not full → write I_rx_data, level+1.
  - I_rx_valid=1 and I_rx_error=1 in the same cycle → the character is discarded and O_err_cnt increments.
  - I_rx_error alone also increments O_err_cnt.
  - O_err_cnt saturates at 2^CNTW-1; no wrap.
- Full:
  - A push while full with no pop in the same cycle drops the character and sets O_overflow.
  - A push while full with a pop (LAUNCH) in the same cycle is accepted; level stays DEPTH, no overflow.
- Pointers wrap modulo DEPTH. Full/empty are derived from an extra pointer bit; O_level = wr_ptr - rd_ptr.
- Flush: I_flush=1 → both pointers = 0 next cycle, level = 0.
  - Flush has priority over a simultaneous push (character discarded, not counted as overflow) and over a simultaneous pop.
  - Flush does not abort a character already launched; the FSM continues its WAIT states.
- Status clear: I_clr_status=1 → O_overflow=0 and O_err_cnt=0.
  - A simultaneous set event wins: the flag/counter takes 1.
- TX FSM:
  - IDLE: if !O_empty and !I_tx_busy → LAUNCH. On this edge: O_tx_data <= head, O_tx_en <= 1, rd_ptr+1.
  - LAUNCH: O_tx_en high for exactly one cycle. → WAIT_BUSY with O_tx_en <= 0 and a 2-bit timer cleared.
  - WAIT_BUSY: I_tx_busy=1 → WAIT_DONE. After 4 cycles without busy → IDLE (character considered sent).
  - WAIT_DONE: I_tx_busy=0 → IDLE.
- Latency: a character pushed at edge k into an empty FIFO, with transmitter idle, gives O_tx_en high in the cycle following edge k+1 (2-cycle latency).
- Back-to-back: the next launch occurs no earlier than the first IDLE cycle after busy falls; at most one O_tx_en per transmitted character.

Optional Feature:
UART_ECHO_UPPER_EN
- Defined: O_tx_data is case-folded at launch. Values 8'h61..8'h7A ('a'..'z') are sent minus 8'h20; all other values are unchanged. Requires DATABITS >= 7; upper bits above 7 pass through.
- Undefined: O_tx_data equals the FIFO head exactly; no folding logic is present.

Test Plan:
- Single char 8'h41 pushed, I_tx_busy model rises 1 cycle after O_tx_en and holds 5208*10 cycles → one O_tx_en pulse 2 cycles after the push, O_tx_data=8'h41, O_level back to 0.
- Burst of 20 chars 8'h00..8'h13 with DEPTH=16, tx held busy → first 16 stored; 4 dropped with O_overflow=1. Release busy → 16 chars echoed in order 8'h00..8'h0F.
- Full FIFO with push coincident with a LAUNCH pop → push accepted, O_level stays 16, O_overflow stays 0.
- 300 I_rx_error pulses with CNTW=8 → O_err_cnt=255. Pulse I_clr_status → 0. Valid+error together → no FIFO write.
- I_flush asserted with level 5 while in WAIT_DONE → level 0 next cycle, current character completes, no further O_tx_en. I_tx_busy never asserted → FSM returns to IDLE after 4 cycles.
- Macro defined: push 8'h61, 8'h7A, 8'h5B → transmitted 8'h41, 8'h5A, 8'h5B. Undefined: 8'h61 transmitted unchanged. Reset asserted mid-burst → all outputs at reset values within the reset cycle.
